// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A) and load path (M).
// Optional busy scoreboard is built when RF_ARB_SCOREBOARD_EN is defined.
module rf_write_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [2:0]  a_addr,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        m_valid,
  input  logic [2:0]  m_addr,
  input  logic [15:0] m_data,
  output logic        m_ready,
  input  logic        reserve_valid,
  input  logic [2:0]  reserve_addr,
  output logic        rf_write_n,
  output logic [2:0]  rf_addr,
  output logic [15:0] rf_data,
  output logic [7:0]  busy
);

  // state   | meaning
  // PRIO_A  | A wins when both ports request
  // PRIO_M  | M wins when both ports request
  typedef enum logic {PRIO_A = 1'b0, PRIO_M = 1'b1} prio_t;

  prio_t prio;
  logic  grant_a;
  logic  grant_m;

  always_comb begin
    grant_a = a_valid && (!m_valid || (prio == PRIO_A));
    grant_m = m_valid && !grant_a;
  end

  assign a_ready = grant_a && !reset;
  assign m_ready = grant_m && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio       <= PRIO_A;
      rf_write_n <= 1'b1;
      rf_addr    <= 3'd0;
      rf_data    <= 16'h0000;
    end else if (grant_a) begin
      prio       <= PRIO_M;
      rf_write_n <= 1'b0;
      rf_addr    <= a_addr;
      rf_data    <= a_data;
    end else if (grant_m) begin
      prio       <= PRIO_A;
      rf_write_n <= 1'b0;
      rf_addr    <= m_addr;
      rf_data    <= m_data;
    end else begin
      rf_write_n <= 1'b1;
    end
  end

`ifdef RF_ARB_SCOREBOARD_EN
  logic [7:0] busy_q;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;

  // Applying the set after the clear makes a same-edge reserve win over the write.
  always_comb begin
    set_mask = reserve_valid ? (8'h01 << reserve_addr) : 8'h00;
    clr_mask = !rf_write_n ? (8'h01 << rf_addr) : 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= 8'h00;
    else       busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

  assign busy = busy_q;
`else
  logic unused_reserve;
  assign unused_reserve = ^{reserve_valid, reserve_addr};
  assign busy = 8'h00;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised and directed bench for rf_write_arbiter with a behavioural model of grant order,
// write-port contents, busy bits and the downstream register file.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, m_valid, reserve_valid;
  logic [2:0]  a_addr, m_addr, reserve_addr;
  logic [15:0] a_data, m_data;
  logic        a_ready, m_ready, rf_write_n;
  logic [2:0]  rf_addr;
  logic [15:0] rf_data;
  logic [7:0]  busy;

  int total = 0;
  int bad = 0;

  rf_write_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
    .rf_write_n(rf_write_n), .rf_addr(rf_addr), .rf_data(rf_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the register file fed by the arbiter outputs.
  logic [15:0] tb_file [8] = '{default: 16'h0000};
  always @(posedge clk) if (!rf_write_n) tb_file[rf_addr] <= rf_data;

  // Model: priority favour, pending write of the output stage, file contents, busy set.
  bit          md_prio_m;
  bit          md_wn;
  logic [2:0]  md_addr;
  logic [15:0] md_data;
  logic [15:0] md_mem [8] = '{default: 16'h0000};
  logic [7:0]  md_busy;
  int          last_g;
  logic        sa, sm, swn;
  logic [2:0]  saddr;
  logic [15:0] sdata;
  logic [7:0]  sbusy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_prio_m = 0;
    md_wn     = 1;
    md_addr   = 3'd0;
    md_data   = 16'h0000;
    md_busy   = 8'h00;
  endtask

  // One clock: compare at negedge, then advance the model at the rising edge.
  task automatic step();
    int g;
    @(negedge clk);
    g = 0;
    if (a_valid && m_valid) g = md_prio_m ? 2 : 1;
    else if (a_valid)       g = 1;
    else if (m_valid)       g = 2;
    chk("a_ready", a_ready, g == 1);
    chk("m_ready", m_ready, g == 2);
    chk("rf_write_n", rf_write_n, md_wn);
    chk("rf_addr", rf_addr, md_addr);
    chk("rf_data", rf_data, md_data);
    chk("busy", busy, md_busy);
    sa = a_ready; sm = m_ready; swn = rf_write_n;
    saddr = rf_addr; sdata = rf_data; sbusy = busy;
    @(posedge clk);
    if (!md_wn) md_mem[md_addr] = md_data;
`ifdef RF_ARB_SCOREBOARD_EN
    if (!md_wn) md_busy[md_addr] = 1'b0;
    if (reserve_valid) md_busy[reserve_addr] = 1'b1;
`endif
    if (g == 1) begin
      md_wn = 0; md_addr = a_addr; md_data = a_data; md_prio_m = 1;
    end else if (g == 2) begin
      md_wn = 0; md_addr = m_addr; md_data = m_data; md_prio_m = 0;
    end else begin
      md_wn = 1;
    end
    last_g = g;
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; m_valid = 0; reserve_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    a_valid = 0; a_addr = 0; a_data = 0;
    m_valid = 0; m_addr = 0; m_data = 0;
    reserve_valid = 0; reserve_addr = 0;
    model_reset();
    #12;
    chk("init_wn", rf_write_n, 1);
    chk("init_busy", busy, 8'h00);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    // Lone ALU request
    a_valid = 1; a_addr = 3'd3; a_data = 16'h1234;
    step();
    chk("single_a_ready", sa, 1);
    a_valid = 0;
    step();
    chk("single_wn_low", swn, 0);
    chk("single_addr", saddr, 3);
    chk("single_data", sdata, 16'h1234);
    step();
    chk("single_wn_high", swn, 1);
    chk("single_file_r3", tb_file[3], 16'h1234);

    // Reset mid-cycle with an ALU request pending, after leaving a write in the stage
    a_valid = 1; a_addr = 3'd6; a_data = 16'hBEEF;
    step();
    #2; reset = 1; #1;
    chk("rst_wn", rf_write_n, 1);
    chk("rst_addr", rf_addr, 0);
    chk("rst_data", rf_data, 16'h0000);
    chk("rst_busy", busy, 8'h00);
    chk("rst_a_ready", a_ready, 0);
    model_reset();
    a_valid = 0;
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    chk("rst_dropped_r6", tb_file[6], 16'h0000);

    // Contention from reset, distinct addresses
    a_valid = 1; a_addr = 3'd0; a_data = 16'h0A00;
    m_valid = 1; m_addr = 3'd1; m_data = 16'h0B01;
    step(); chk("cont_g1_a", sa, 1);
    a_addr = 3'd2; a_data = 16'h0A02;
    step(); chk("cont_g2_m", sm, 1); chk("cont_wn2", swn, 0);
    m_addr = 3'd3; m_data = 16'h0B03;
    step(); chk("cont_g3_a", sa, 1); chk("cont_wn3", swn, 0);
    a_addr = 3'd4; a_data = 16'h0A04;
    step(); chk("cont_g4_m", sm, 1); chk("cont_wn4", swn, 0);
    idle_inputs();
    step(); chk("cont_wn5", swn, 0);
    step(); chk("cont_wn6", swn, 1);

    // Same address, prio favours A
    a_valid = 1; a_addr = 3'd5; a_data = 16'hAAAA;
    m_valid = 1; m_addr = 3'd5; m_data = 16'h5555;
    step(); chk("same_first_a", sa, 1);
    a_valid = 0;
    step(); chk("same_then_m", sm, 1);
    m_valid = 0;
    step(); step();
    chk("same_r5_final", tb_file[5], 16'h5555);

`ifdef RF_ARB_SCOREBOARD_EN
    reserve_valid = 1; reserve_addr = 3'd2;
    step();
    reserve_valid = 0;
    step(); chk("sb_reserved", sbusy, 8'h04);
    a_valid = 1; a_addr = 3'd2; a_data = 16'h2222;
    step();
    a_valid = 0; reserve_valid = 1; reserve_addr = 3'd2;
    step(); chk("sb_issue_edge_wn", swn, 0);
    reserve_valid = 0;
    step(); chk("sb_set_wins", sbusy, 8'h04);
    m_valid = 1; m_addr = 3'd2; m_data = 16'h3333;
    step();
    m_valid = 0;
    step(); chk("sb_still_busy_n1", sbusy, 8'h04);
    step(); chk("sb_cleared", sbusy, 8'h00);
`else
    reserve_valid = 1; reserve_addr = 3'd2;
    step();
    reserve_valid = 0;
    step(); chk("cfg_off_busy", sbusy, 8'h00);
`endif

    // Randomised traffic: requesters hold until accepted
    for (int i = 0; i < 800; i++) begin
      if (!a_valid || last_g == 1) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_addr  = 3'($urandom_range(0, 7));
        a_data  = 16'($urandom);
      end
      if (!m_valid || last_g == 2) begin
        m_valid = ($urandom_range(0, 3) != 0);
        m_addr  = 3'($urandom_range(0, 7));
        m_data  = 16'($urandom);
      end
      reserve_valid = ($urandom_range(0, 3) == 0);
      reserve_addr  = 3'($urandom_range(0, 7));
      step();
    end
    idle_inputs();
    step(); step();
    for (int r = 0; r < 8; r++) chk("final_file", tb_file[r], md_mem[r]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
